exp_golomb_k_codec: RTL and testbench
=====================================

# exp_golomb_k_codec

Parametrised serial Exp-Golomb codec of order K, the generalised successor to the fixed 8-bit encoder/decoder pair. It encodes W-bit words, unsigned or signed (se(v) mapping), into a bit-serial stream with valid/ready backpressure. An independent decoder turns a bit-serial stream back into words and flags malformed or out-of-range codewords. The codec sits between word-level pipeline stages and the bit-serial packer/unpacker of the bitstream path.

## Interface
- W, 8: data word width (W ≥ 2).
- K, 0: Exp-Golomb order (0 ≤ K < W).
- SIGNED, 0: 1 selects signed mapping s>0 → 2s−1, s≤0 → −2s; 0 selects plain unsigned.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- enc_valid_i  in  1  word available to encode.
- enc_ready_o  out  1  encoder idle and able to accept a word.
- enc_data_i  in  W  word to encode (two's complement when SIGNED=1).
- ser_valid_o  out  1  ser_bit_o is valid.
- ser_bit_o  out  1  current code bit, MSB-first.
- ser_last_o  out  1  current bit is the final bit of the codeword.
- ser_ready_i  in  1  downstream consumes the bit this cycle.
- dec_bit_i  in  1  serial code bit into the decoder.
- dec_bit_valid_i  in  1  dec_bit_i is valid. No backpressure; the decoder always accepts.
- dec_valid_o  out  1  one-cycle pulse; dec_data_o is valid.
- dec_data_o  out  W  decoded word.
- dec_err_o  out  1  one-cycle pulse; codeword rejected.
- busy_o  out  1  encoder is not IDLE, or the decoder is mid-codeword.

## Operation
- Code definition:
  - The mapped value is m (W+1 bits internally), x = m + 2^K, and n = floor(log2 x).
  - The codeword is (n−K) zeros followed by the n+1 bits of x, MSB-first. The first of these bits is the '1' that ends the prefix.
  - Length is 2n−K+1; the maximum n is W.
- Encoder FSM states IDLE, PREFIX, SUFFIX:
  - enc_ready_o = (state == IDLE). A word is accepted on enc_valid_i && enc_ready_o.
  - On accept, register x, the prefix count (n−K) and the suffix count (n+1). Go to PREFIX if n > K, otherwise go to SUFFIX.
  - ser_valid_o = 1 in PREFIX and SUFFIX. The bit advances only on ser_valid_o && ser_ready_i. ser_bit_o, ser_last_o and the counts hold while ser_ready_i = 0.
  - PREFIX emits 0s. After the last prefix bit is consumed, go to SUFFIX.
  - SUFFIX emits x[n] down to x[0]. ser_last_o = 1 exactly on x[0]. Consuming that bit returns the FSM to IDLE.
- Decoder FSM states ZEROS, BITS:
  - In ZEROS, count zeros in z, which saturates at W−K+1. A '1' loads acc = 1 and sets the remaining count to z+K. If z+K = 0, the word completes immediately; otherwise go to BITS.
  - In BITS, acc = {acc, bit}. When the remaining count reaches 0, compute v = acc − 2^K.
  - Unsigned: the word is valid if v ≤ 2^W−1.
  - Signed: unmap with odd v → (v+1)/2 and even v → −(v/2). The word is valid if the result fits in W-bit two's complement.
  - If valid, pulse dec_valid_o with dec_data_o; otherwise pulse dec_err_o. Either way, return to ZEROS with z = 0.
  - Prefix error: on the (W−K+1)-th consecutive zero, pulse dec_err_o and restart at z = 0.
- Only bits with dec_bit_valid_i = 1 are considered; gaps are allowed anywhere in a codeword.
- Encoder and decoder are fully independent and may run simultaneously.

## Timing
- Reset values:
  - enc_ready_o = 1.
  - ser_valid_o, ser_bit_o, ser_last_o, dec_valid_o, dec_err_o and busy_o = 0.
  - dec_data_o = 0.
  - Both FSMs in their initial states (IDLE, ZEROS) with counters cleared.
- Reset mid-operation aborts immediately. No ser_last_o is emitted and the partial decoder word is discarded.
- Encoder:
  - The first bit is valid the cycle after accept. With ser_ready_i held at 1, the codeword occupies 2n−K+1 consecutive cycles.
  - enc_ready_o rises the cycle after the ser_last_o handshake, so back-to-back words cost length+1 cycles.
- Decoder: dec_valid_o and dec_err_o are registered and assert the cycle after the final (or offending) bit is accepted. dec_data_o holds until the next dec_valid_o.
- All outputs are registered; there are no combinational paths from inputs to outputs except none required.

## Test plan
- W=8, K=0, unsigned, ser_ready_i=1:
  - Encode 0 → bit sequence "1" with ser_last_o on it. enc_ready_o is back high 2 cycles after accept.
  - Encode 5 → "00110"; encode 255 → 8 zeros then "100000000" (17 bits).
- K=2, unsigned: encode 5 → "01001"; encode 0 → "100". Loop ser_bit_o into dec_bit_i and check dec_data_o = 5, then 0.
- SIGNED=1, K=0:
  - Encode −3 → "00111" and +3 → "00110".
  - Encode −128 → 17 bits (x = 257).
  - Decoder loopback returns −3, +3 and −128.
- Backpressure: encode 5 with ser_ready_i toggling 1,0,0,1,...
  - Bits hold during stalls and the stream is still "00110".
  - Decoder fed with random dec_bit_valid_i gaps still yields 5.
- Decoder errors, W=8, K=0:
  - Nine zeros → dec_err_o pulse after the 9th bit.
  - "00000000111111111" (v=510) → dec_err_o, no dec_valid_o.
  - The following "1" decodes to 0.
- Assert rst_n low during PREFIX of 255:
  - All outputs go to their reset values asynchronously.
  - After release, encoding 1 gives "010" cleanly.

Source files
------------

// File: rtl/exp_golomb_k_codec.sv
// Serial Exp-Golomb codec of order K: a word encoder with a valid/ready bit stream,
// and an independent bit-serial decoder that flags malformed or out-of-range codewords.
module exp_golomb_k_codec #(
    parameter int W      = 8,
    parameter int K      = 0,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enc_valid_i,
    output logic         enc_ready_o,
    input  logic [W-1:0] enc_data_i,
    output logic         ser_valid_o,
    output logic         ser_bit_o,
    output logic         ser_last_o,
    input  logic         ser_ready_i,
    input  logic         dec_bit_i,
    input  logic         dec_bit_valid_i,
    output logic         dec_valid_o,
    output logic [W-1:0] dec_data_o,
    output logic         dec_err_o,
    output logic         busy_o
);
    localparam int NW = $clog2(W + 1);
    localparam logic [W:0]    ONE   = (W + 1)'(1);
    localparam logic [W:0]    POW_K = ONE << K;
    localparam logic [W:0]    HALF  = ONE << (W - 1);
    localparam logic [NW-1:0] K_N   = NW'(K);
    localparam logic [NW-1:0] ZMAX  = NW'(W - K);

    typedef enum logic [1:0] {E_IDLE, E_PREFIX, E_SUFFIX} enc_state_t;
    typedef enum logic {D_ZEROS, D_BITS} dec_state_t;

    enc_state_t    enc_state_q, enc_state_d;
    logic [W:0]    x_q, x_d, m_new, x_new;
    logic [NW-1:0] pcnt_q, pcnt_d, bidx_q, bidx_d, n_new;
    logic          enc_ready_q, enc_ready_d, ser_valid_q, ser_valid_d;
    logic          ser_bit_q, ser_bit_d, ser_last_q, ser_last_d;

    dec_state_t    dec_state_q, dec_state_d;
    logic [NW-1:0] z_q, z_d, rem_q, rem_d;
    logic [W:0]    acc_q, acc_d, acc_fin, v, mag;
    logic          done, perr, word_ok;
    logic [W-1:0]  word;
    logic          dec_valid_q, dec_valid_d, dec_err_q, dec_err_d, busy_q, busy_d;
    logic [W-1:0]  dec_data_q, dec_data_d;

    // Value mapping and codeword sizing for the word presented at the input
    always_comb begin
        if (SIGNED != 0) begin
            if (!enc_data_i[W-1] && (enc_data_i != '0))
                m_new = {enc_data_i, 1'b0} - ONE;
            else
                m_new = ~{enc_data_i, 1'b0} + ONE;
        end else begin
            m_new = {1'b0, enc_data_i};
        end
        x_new = m_new + POW_K;
        n_new = '0;
        for (int i = 0; i <= W; i++)
            if (x_new[i]) n_new = NW'(i);
    end

    always_comb begin
        enc_state_d = enc_state_q;
        x_d         = x_q;
        pcnt_d      = pcnt_q;
        bidx_d      = bidx_q;
        case (enc_state_q)
            E_IDLE: if (enc_valid_i) begin
                x_d    = x_new;
                bidx_d = n_new;
                if (n_new > K_N) begin
                    enc_state_d = E_PREFIX;
                    pcnt_d      = n_new - K_N - NW'(1);
                end else begin
                    enc_state_d = E_SUFFIX;
                end
            end
            E_PREFIX: if (ser_ready_i) begin
                if (pcnt_q == '0) enc_state_d = E_SUFFIX;
                else              pcnt_d = pcnt_q - NW'(1);
            end
            E_SUFFIX: if (ser_ready_i) begin
                if (bidx_q == '0) enc_state_d = E_IDLE;
                else              bidx_d = bidx_q - NW'(1);
            end
            default: enc_state_d = E_IDLE;
        endcase
        // Output flops are loaded from the next state so they line up with it
        enc_ready_d = (enc_state_d == E_IDLE);
        ser_valid_d = (enc_state_d != E_IDLE);
        ser_bit_d   = (enc_state_d == E_SUFFIX) && x_d[bidx_d];
        ser_last_d  = (enc_state_d == E_SUFFIX) && (bidx_d == '0);
    end

    always_comb begin
        dec_state_d = dec_state_q;
        z_d         = z_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        acc_fin     = acc_q;
        done        = 1'b0;
        perr        = 1'b0;
        if (dec_bit_valid_i) begin
            case (dec_state_q)
                D_ZEROS: begin
                    if (!dec_bit_i) begin
                        if (z_q == ZMAX) begin
                            perr = 1'b1;
                            z_d  = '0;
                        end else begin
                            z_d = z_q + NW'(1);
                        end
                    end else begin
                        acc_d = ONE;
                        rem_d = z_q + K_N;
                        z_d   = '0;
                        if ((z_q + K_N) == '0) begin
                            done    = 1'b1;
                            acc_fin = ONE;
                        end else begin
                            dec_state_d = D_BITS;
                        end
                    end
                end
                D_BITS: begin
                    acc_d = {acc_q[W-1:0], dec_bit_i};
                    rem_d = rem_q - NW'(1);
                    if (rem_q == NW'(1)) begin
                        done        = 1'b1;
                        acc_fin     = acc_d;
                        dec_state_d = D_ZEROS;
                    end
                end
                default: dec_state_d = D_ZEROS;
            endcase
        end
        // Odd v unmaps to the positive (v+1)/2, even v to -(v/2)
        v   = acc_fin - POW_K;
        mag = {1'b0, v[W:1]} + {{W{1'b0}}, v[0]};
        if (SIGNED != 0) begin
            word_ok = v[0] ? (mag < HALF) : (mag <= HALF);
            word    = v[0] ? mag[W-1:0] : (W'(0) - mag[W-1:0]);
        end else begin
            word_ok = !v[W];
            word    = v[W-1:0];
        end
        dec_valid_d = done && word_ok;
        dec_err_d   = perr || (done && !word_ok);
        dec_data_d  = (done && word_ok) ? word : dec_data_q;
        busy_d      = (enc_state_d != E_IDLE) || (dec_state_d == D_BITS) || (z_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_state_q <= E_IDLE;
            x_q         <= '0;
            pcnt_q      <= '0;
            bidx_q      <= '0;
            enc_ready_q <= 1'b1;
            ser_valid_q <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_last_q  <= 1'b0;
            dec_state_q <= D_ZEROS;
            z_q         <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            dec_valid_q <= 1'b0;
            dec_err_q   <= 1'b0;
            dec_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            enc_state_q <= enc_state_d;
            x_q         <= x_d;
            pcnt_q      <= pcnt_d;
            bidx_q      <= bidx_d;
            enc_ready_q <= enc_ready_d;
            ser_valid_q <= ser_valid_d;
            ser_bit_q   <= ser_bit_d;
            ser_last_q  <= ser_last_d;
            dec_state_q <= dec_state_d;
            z_q         <= z_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            dec_valid_q <= dec_valid_d;
            dec_err_q   <= dec_err_d;
            dec_data_q  <= dec_data_d;
            busy_q      <= busy_d;
        end
    end

    assign enc_ready_o = enc_ready_q;
    assign ser_valid_o = ser_valid_q;
    assign ser_bit_o   = ser_bit_q;
    assign ser_last_o  = ser_last_q;
    assign dec_valid_o = dec_valid_q;
    assign dec_err_o   = dec_err_q;
    assign dec_data_o  = dec_data_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_exp_golomb_k_codec.sv
// Scoreboard bench for exp_golomb_k_codec: three instances (K=0 unsigned, K=2 unsigned,
// K=0 signed), encoder streams looped into decoders, plus direct decoder error stimulus.
module tb_exp_golomb_k_codec;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_ready = 1'b1;
    logic       fb = 1'b1;
    logic       ext_bit = 1'b0, ext_valid = 1'b0;
    logic [2:0] enc_valid = '0;
    logic [7:0] enc_data [3];
    logic [2:0] enc_ready, ser_valid, ser_bit, ser_last, dec_valid, dec_err, busy;
    logic [7:0] dec_data [3];
    logic       a_dbit, a_dval;
    logic       bp_stop;

    int n_vec = 0, n_err = 0;
    logic [31:0] enc_q [3][$];
    logic [31:0] dec_q [3][$];
    int acc [3], cnt [3];
    logic hold_pend [3], hold_bit [3], hold_last [3];

    always #5 clk = ~clk;

    assign a_dbit = fb ? ser_bit[0] : ext_bit;
    assign a_dval = fb ? (ser_valid[0] & ser_ready) : ext_valid;

    exp_golomb_k_codec #(.W(8), .K(0), .SIGNED(0)) u_a (
        .clk(clk), .rst_n(rst_n), .enc_valid_i(enc_valid[0]), .enc_ready_o(enc_ready[0]),
        .enc_data_i(enc_data[0]), .ser_valid_o(ser_valid[0]), .ser_bit_o(ser_bit[0]),
        .ser_last_o(ser_last[0]), .ser_ready_i(ser_ready), .dec_bit_i(a_dbit),
        .dec_bit_valid_i(a_dval), .dec_valid_o(dec_valid[0]), .dec_data_o(dec_data[0]),
        .dec_err_o(dec_err[0]), .busy_o(busy[0]));

    exp_golomb_k_codec #(.W(8), .K(2), .SIGNED(0)) u_b (
        .clk(clk), .rst_n(rst_n), .enc_valid_i(enc_valid[1]), .enc_ready_o(enc_ready[1]),
        .enc_data_i(enc_data[1]), .ser_valid_o(ser_valid[1]), .ser_bit_o(ser_bit[1]),
        .ser_last_o(ser_last[1]), .ser_ready_i(ser_ready), .dec_bit_i(ser_bit[1]),
        .dec_bit_valid_i(ser_valid[1] & ser_ready), .dec_valid_o(dec_valid[1]),
        .dec_data_o(dec_data[1]), .dec_err_o(dec_err[1]), .busy_o(busy[1]));

    exp_golomb_k_codec #(.W(8), .K(0), .SIGNED(1)) u_c (
        .clk(clk), .rst_n(rst_n), .enc_valid_i(enc_valid[2]), .enc_ready_o(enc_ready[2]),
        .enc_data_i(enc_data[2]), .ser_valid_o(ser_valid[2]), .ser_bit_o(ser_bit[2]),
        .ser_last_o(ser_last[2]), .ser_ready_i(ser_ready), .dec_bit_i(ser_bit[2]),
        .dec_bit_valid_i(ser_valid[2] & ser_ready), .dec_valid_o(dec_valid[2]),
        .dec_data_o(dec_data[2]), .dec_err_o(dec_err[2]), .busy_o(busy[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference codeword: {length[7:0], x[23:0]}; leading zeros are implied by length
    function automatic logic [31:0] code_of(input int k, input bit sg, input logic [7:0] d);
        int s, m, x, n, len;
        s = sg ? int'($signed(d)) : int'(d);
        m = sg ? ((s > 0) ? 2 * s - 1 : -2 * s) : s;
        x = m + (1 << k);
        n = 0;
        for (int b = 0; b < 31; b++) if (x[b]) n = b;
        len = 2 * n - k + 1;
        return {len[7:0], x[23:0]};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                acc[i] = 0; cnt[i] = 0; hold_pend[i] = 1'b0;
            end else begin
                if (hold_pend[i])
                    check($sformatf("hold%0d", i), {29'd0, ser_valid[i], ser_bit[i], ser_last[i]},
                          {29'd0, 1'b1, hold_bit[i], hold_last[i]});
                hold_pend[i] = ser_valid[i] && !ser_ready;
                hold_bit[i]  = ser_bit[i];
                hold_last[i] = ser_last[i];
                if (ser_valid[i] && ser_ready) begin
                    acc[i] = (acc[i] << 1) | int'(ser_bit[i]);
                    cnt[i]++;
                    if (ser_last[i]) begin
                        if (enc_q[i].size() == 0) check($sformatf("enc%0d_unexpected", i), 1, 0);
                        else check($sformatf("enc%0d_code", i), {cnt[i][7:0], acc[i][23:0]},
                                   enc_q[i].pop_front());
                        $display("enc%0d codeword len=%0d bits=%b", i, cnt[i], acc[i][16:0]);
                        acc[i] = 0; cnt[i] = 0;
                    end
                end
                if (dec_valid[i] || dec_err[i]) begin
                    if (dec_q[i].size() == 0) check($sformatf("dec%0d_unexpected", i), 1, 0);
                    else check($sformatf("dec%0d_word", i),
                               dec_err[i] ? 32'h100 : {24'd0, dec_data[i]}, dec_q[i].pop_front());
                    $display("dec%0d err=%0d data=%h", i, dec_err[i], dec_data[i]);
                end
            end
        end
    end

    task automatic enc_send(input int id, input logic [7:0] d);
        int t = 0;
        enc_q[id].push_back(code_of((id == 1) ? 2 : 0, id == 2, d));
        if (id != 0 || fb) dec_q[id].push_back({24'd0, d});
        while (!enc_ready[id] && t < 300) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 300) check("accept_timeout", 0, 1);
        enc_valid[id] = 1'b1;
        enc_data[id]  = d;
        @(posedge clk); #1;
        enc_valid[id] = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((enc_q[0].size() + enc_q[1].size() + enc_q[2].size() + dec_q[0].size() +
                dec_q[1].size() + dec_q[2].size()) != 0 && t < 400) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 400) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic feed_bits(input logic [31:0] val, input int len, input logic [31:0] exp);
        logic [31:0] vv;
        vv = val;
        dec_q[0].push_back(exp);
        for (int i = len - 1; i >= 0; i--) begin
            ext_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            ext_bit = vv[i]; ext_valid = 1'b1;
            @(posedge clk); #1;
        end
        ext_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, enc_ready[0]}, 1);
        check({tag, "_ser"}, {29'd0, ser_valid[0], ser_bit[0], ser_last[0]}, 0);
        check({tag, "_dec"}, {22'd0, dec_valid[0], dec_err[0], dec_data[0]}, 0);
        check({tag, "_busy"}, {31'd0, busy[0]}, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) enc_data[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Encode 0: single '1' with last, ready back after the last handshake
        enc_send(0, 8'd0);
        check("enc0_ready_low", {31'd0, enc_ready[0]}, 0);
        check("enc0_first_bit", {29'd0, ser_valid[0], ser_bit[0], ser_last[0]}, 32'b111);
        check("enc0_busy", {31'd0, busy[0]}, 1);
        @(posedge clk); #1;
        check("enc0_ready_back", {31'd0, enc_ready[0]}, 1);
        drain();

        enc_send(0, 8'd5);
        enc_send(0, 8'd255);
        enc_send(1, 8'd5);
        enc_send(1, 8'd0);
        enc_send(2, 8'hFD);
        enc_send(2, 8'd3);
        enc_send(2, 8'h80);
        drain();
        for (int r = 0; r < 6; r++)
            for (int id = 0; id < 3; id++) enc_send(id, 8'($urandom));
        drain();

        // Backpressure with ready pattern 1,0,0,1 repeating
        bp_stop = 1'b0;
        fork
            begin
                enc_send(0, 8'd5);
                enc_send(2, 8'h80);
                drain();
                bp_stop = 1'b1;
            end
            begin
                int ph = 0;
                while (!bp_stop) begin
                    ser_ready = (ph == 0 || ph == 3);
                    ph = (ph + 1) % 4;
                    @(posedge clk); #1;
                end
                ser_ready = 1'b1;
            end
        join
        drain();

        // Direct decoder stimulus with random valid gaps
        fb = 1'b0;
        feed_bits(32'b00110, 5, 32'd5);
        feed_bits(32'd0, 9, 32'h100);
        feed_bits(32'h001FF, 17, 32'h100);
        feed_bits(32'd1, 1, 32'd0);
        feed_bits(32'h00100, 17, 32'd255);
        drain();
        fb = 1'b1;

        // Asynchronous reset during the prefix of 255
        enc_send(0, 8'd255);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        enc_q[0].delete();
        dec_q[0].delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        enc_send(0, 8'd1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
